// File: rtl/spi_master.sv
// SPI mode-0 byte master; CS_n held low across a burst until a byte flagged last completes.
// Latency: RX_DV at 1+S+16H after an idle accept; backpressure via o_TX_Ready (high only in IDLE/WAIT_NEXT).
module spi_master #(
    parameter int CLKS_PER_HALF_BIT = 4,
    parameter int CS_SETUP_CLKS     = 2,
    parameter int CS_INACTIVE_CLKS  = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    input  logic       i_TX_Last,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_SPI_Clk,
    input  logic       i_SPI_MISO,
    output logic       o_SPI_MOSI,
    output logic       o_SPI_CS_n
);

    localparam int HALF_W  = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
    localparam int SETUP_W = (CS_SETUP_CLKS > 1)     ? $clog2(CS_SETUP_CLKS)     : 1;
    localparam int INACT_W = (CS_INACTIVE_CLKS > 1)  ? $clog2(CS_INACTIVE_CLKS)  : 1;

    localparam logic [HALF_W-1:0]  HALF_MAX  = HALF_W'(CLKS_PER_HALF_BIT - 1);
    localparam logic [SETUP_W-1:0] SETUP_MAX = SETUP_W'(CS_SETUP_CLKS - 1);
    localparam logic [INACT_W-1:0] INACT_MAX = INACT_W'(CS_INACTIVE_CLKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        TRANSFER,
        WAIT_NEXT,
        CS_HOLD,
        CS_INACTIVE
    } state_t;

    state_t             state_q, state_d;
    logic [HALF_W-1:0]  half_cnt_q, half_cnt_d;
    logic [SETUP_W-1:0] setup_cnt_q, setup_cnt_d;
    logic [INACT_W-1:0] inact_cnt_q, inact_cnt_d;
    logic [3:0]         edge_cnt_q, edge_cnt_d;
    logic [7:0]         tx_shift_q, tx_shift_d;
    logic [7:0]         rx_shift_q, rx_shift_d;
    logic [7:0]         rx_byte_q, rx_byte_d;
    logic               last_q, last_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic               cs_n_q, cs_n_d;
    logic               rx_dv_q, rx_dv_d;
    logic               ready;
    logic               accept;

    assign ready  = (state_q == IDLE) || (state_q == WAIT_NEXT);
    assign accept = i_TX_DV && ready;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q     <= IDLE;
            half_cnt_q  <= '0;
            setup_cnt_q <= '0;
            inact_cnt_q <= '0;
            edge_cnt_q  <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_byte_q   <= '0;
            last_q      <= 1'b0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            rx_dv_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            half_cnt_q  <= half_cnt_d;
            setup_cnt_q <= setup_cnt_d;
            inact_cnt_q <= inact_cnt_d;
            edge_cnt_q  <= edge_cnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            last_q      <= last_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
            rx_dv_q     <= rx_dv_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        half_cnt_d  = half_cnt_q;
        setup_cnt_d = setup_cnt_q;
        inact_cnt_d = inact_cnt_q;
        edge_cnt_d  = edge_cnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_byte_d   = rx_byte_q;
        last_d      = last_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;
        rx_dv_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = CS_SETUP;
                    tx_shift_d  = i_TX_Byte;
                    mosi_d      = i_TX_Byte[7];
                    last_d      = i_TX_Last;
                    cs_n_d      = 1'b0;
                    setup_cnt_d = '0;
                end
            end
            CS_SETUP: begin
                if (setup_cnt_q == SETUP_MAX) begin
                    setup_cnt_d = '0;
                    half_cnt_d  = '0;
                    state_d     = TRANSFER;
                end else begin
                    setup_cnt_d = setup_cnt_q + 1'b1;
                end
            end
            TRANSFER: begin
                if (half_cnt_q == HALF_MAX) begin
                    half_cnt_d = '0;
                    sclk_d     = ~sclk_q;
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    // SCLK currently high means this toggle is a falling edge
                    if (sclk_q) begin
                        rx_shift_d = {rx_shift_q[6:0], i_SPI_MISO};
                        if (edge_cnt_q == 4'd15) begin
                            rx_byte_d = {rx_shift_q[6:0], i_SPI_MISO};
                            rx_dv_d   = 1'b1;
                            state_d   = last_q ? CS_HOLD : WAIT_NEXT;
                        end else begin
                            mosi_d     = tx_shift_q[6];
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        end
                    end
                end else begin
                    half_cnt_d = half_cnt_q + 1'b1;
                end
            end
            WAIT_NEXT: begin
                if (accept) begin
                    state_d    = TRANSFER;
                    tx_shift_d = i_TX_Byte;
                    mosi_d     = i_TX_Byte[7];
                    last_d     = i_TX_Last;
                    half_cnt_d = '0;
                end
            end
            CS_HOLD: begin
                if (half_cnt_q == HALF_MAX) begin
                    half_cnt_d = '0;
                    cs_n_d     = 1'b1;
                    state_d    = CS_INACTIVE;
                end else begin
                    half_cnt_d = half_cnt_q + 1'b1;
                end
            end
            CS_INACTIVE: begin
                if (inact_cnt_q == INACT_MAX) begin
                    inact_cnt_d = '0;
                    state_d     = IDLE;
                end else begin
                    inact_cnt_d = inact_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_TX_Ready = ready;
    assign o_RX_DV    = rx_dv_q;
    assign o_RX_Byte  = rx_byte_q;
    assign o_SPI_Clk  = sclk_q;
    assign o_SPI_MOSI = mosi_q;
    assign o_SPI_CS_n = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: mode-0 slave model, scoreboard on o_RX_DV, directed timing plus random bursts.
`timescale 1ns/1ps
module tb_spi_master;
    localparam int H  = 2;
    localparam int S  = 2;
    localparam int CI = 4;

    logic       i_Clk = 1'b0;
    logic       i_Rst = 1'b1;
    logic [7:0] i_TX_Byte = 8'h00;
    logic       i_TX_DV = 1'b0;
    logic       i_TX_Last = 1'b0;
    logic       o_TX_Ready, o_RX_DV, o_SPI_Clk, o_SPI_MOSI, o_SPI_CS_n;
    logic [7:0] o_RX_Byte;
    logic       i_SPI_MISO;
    logic       miso_slv = 1'b0;
    logic       loopback = 1'b0;

    assign i_SPI_MISO = loopback ? o_SPI_MOSI : miso_slv;

    spi_master #(.CLKS_PER_HALF_BIT(H), .CS_SETUP_CLKS(S), .CS_INACTIVE_CLKS(CI)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_TX_Byte(i_TX_Byte), .i_TX_DV(i_TX_DV),
        .i_TX_Last(i_TX_Last), .o_TX_Ready(o_TX_Ready), .o_RX_DV(o_RX_DV),
        .o_RX_Byte(o_RX_Byte), .o_SPI_Clk(o_SPI_Clk), .i_SPI_MISO(i_SPI_MISO),
        .o_SPI_MOSI(o_SPI_MOSI), .o_SPI_CS_n(o_SPI_CS_n)
    );

    always #5 i_Clk = ~i_Clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Slave model: launches MISO MSb-first on SCLK rising edges, captures MOSI there too.
    logic [7:0] slv_resp_q[$];
    logic [7:0] slv_cur = 8'h00;
    logic [7:0] slv_mosi_sh = 8'h00;
    logic [7:0] slv_mosi_byte = 8'h00;
    int         slv_bit = 0;

    always @(posedge o_SPI_Clk) begin
        if (slv_bit == 0) slv_cur = (slv_resp_q.size() > 0) ? slv_resp_q.pop_front() : 8'h00;
        slv_mosi_sh = {slv_mosi_sh[6:0], o_SPI_MOSI};
        miso_slv <= slv_cur[7 - slv_bit];
        slv_bit++;
        if (slv_bit == 8) begin
            slv_bit = 0;
            slv_mosi_byte = slv_mosi_sh;
        end
    end

    always @(posedge o_SPI_CS_n) slv_bit = 0;

    // Scoreboard and event monitor
    typedef struct {
        logic [7:0] rx;
        logic [7:0] tx;
    } exp_t;
    exp_t exp_q[$];

    int cyc = 0;
    always @(posedge i_Clk) cyc <= cyc + 1;

    int acc_cyc = 0, cs_rise_cyc = 0, rdy_rise_cyc = 0, last_tog_cyc = 0;
    int sclk_toggles = 0, cs_rise_cnt = 0, rxdv_cnt = 0, tog_idx = 0;
    int rxdv_cyc_q[$];
    logic sclk_prev = 1'b0, cs_prev = 1'b1, rdy_prev = 1'b1;

    always @(negedge i_Clk) begin
        exp_t e;
        if (!i_Rst && i_TX_DV && o_TX_Ready) acc_cyc = cyc;
        if (o_SPI_CS_n) tog_idx = 0;
        if (o_SPI_Clk != sclk_prev) begin
            sclk_toggles++;
            if (!o_SPI_CS_n) begin
                if (tog_idx != 0) check("half_period", cyc - last_tog_cyc, H);
                tog_idx = (tog_idx + 1) % 16;
            end
            last_tog_cyc = cyc;
        end
        sclk_prev = o_SPI_Clk;
        if (o_SPI_CS_n && !cs_prev) begin
            cs_rise_cyc = cyc;
            cs_rise_cnt++;
        end
        cs_prev = o_SPI_CS_n;
        if (o_TX_Ready && !rdy_prev) rdy_rise_cyc = cyc;
        rdy_prev = o_TX_Ready;
        if (o_RX_DV) begin
            rxdv_cnt++;
            rxdv_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("rx_unexpected", int'(o_RX_Byte), -1);
            end else begin
                e = exp_q.pop_front();
                check("rx_byte", int'(o_RX_Byte), int'(e.rx));
                check("mosi_byte", int'(slv_mosi_byte), int'(e.tx));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_Clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic last, input logic [7:0] resp);
        int n;
        exp_t e;
        n = 0;
        while (!o_TX_Ready && n < 2000) begin
            idle(1);
            n++;
        end
        if (!o_TX_Ready) begin
            check("ready_timeout", int'(o_TX_Ready), 1);
            return;
        end
        e.rx = loopback ? b : resp;
        e.tx = b;
        exp_q.push_back(e);
        if (!loopback) slv_resp_q.push_back(resp);
        i_TX_Byte = b;
        i_TX_Last = last;
        i_TX_DV   = 1'b1;
        idle(1);
        i_TX_DV   = 1'b0;
    endtask

    task automatic wait_rx(input int target);
        int n;
        n = 0;
        while (rxdv_cnt < target && n < 3000) begin
            idle(1);
            n++;
        end
        if (rxdv_cnt < target) check("rx_timeout", rxdv_cnt, target);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(o_TX_Ready && o_SPI_CS_n) && n < 3000) begin
            idle(1);
            n++;
        end
        if (!(o_TX_Ready && o_SPI_CS_n)) check("idle_timeout", int'(o_TX_Ready), 1);
        idle(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, bad, n, rx0;
        logic [7:0] b;
        logic       last;

        idle(3);
        check("rst_cs_n", int'(o_SPI_CS_n), 1);
        check("rst_sclk", int'(o_SPI_Clk), 0);
        check("rst_mosi", int'(o_SPI_MOSI), 0);
        check("rst_rx_dv", int'(o_RX_DV), 0);
        check("rst_rx_byte", int'(o_RX_Byte), 0);
        check("rst_ready", int'(o_TX_Ready), 1);
        i_Rst = 1'b0;
        idle(2);

        // Single byte: timing from the accept cycle
        rxdv_cyc_q.delete();
        sclk_toggles = 0;
        send(8'hA5, 1'b1, 8'h3C);
        wait_rx(1);
        wait_idle();
        check("t1_rx_dv_cycle", rxdv_cyc_q[0] - acc_cyc, 1 + S + 16 * H);
        check("t1_cs_rise_cycle", cs_rise_cyc - acc_cyc, 1 + S + 17 * H);
        check("t1_ready_cycle", rdy_rise_cyc - acc_cyc, 1 + S + 17 * H + CI);
        check("t1_toggles", sclk_toggles, 16);

        // Back-to-back burst, second byte accepted in the RX_DV cycle
        rxdv_cyc_q.delete();
        sclk_toggles = 0;
        cs_rise_cnt = 0;
        send(8'h01, 1'b0, 8'hE7);
        send(8'h80, 1'b1, 8'h42);
        wait_rx(3);
        wait_idle();
        check("burst_toggles", sclk_toggles, 32);
        check("burst_rx_count", rxdv_cyc_q.size(), 2);
        if (rxdv_cyc_q.size() == 2) begin
            check("burst_rx_gap", rxdv_cyc_q[1] - rxdv_cyc_q[0], 1 + 16 * H);
            check("burst_cs_rise_after_last", cs_rise_cyc - rxdv_cyc_q[1], H);
        end
        check("burst_cs_rises", cs_rise_cnt, 1);

        // Loopback
        loopback = 1'b1;
        send(8'h5A, 1'b1, 8'h00);
        wait_rx(4);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            send(8'($urandom), 1'b1, 8'h00);
            wait_rx(5 + i);
            wait_idle();
        end
        loopback = 1'b0;

        // Strobes while not ready must be dropped
        sclk_toggles = 0;
        rx0 = rxdv_cnt;
        send(8'h96, 1'b1, 8'hD2);
        idle(8);
        i_TX_Byte = 8'hFF;
        i_TX_Last = 1'b1;
        i_TX_DV = 1'b1;
        idle(1);
        i_TX_DV = 1'b0;
        n = 0;
        while (!o_SPI_CS_n && n < 200) begin
            idle(1);
            n++;
        end
        i_TX_DV = 1'b1;
        idle(1);
        i_TX_DV = 1'b0;
        wait_idle();
        idle(20);
        check("drop_toggles", sclk_toggles, 16);
        check("drop_rx_count", rxdv_cnt - rx0, 1);
        check("drop_exp_empty", exp_q.size(), 0);
        check("drop_cs_idle", int'(o_SPI_CS_n), 1);

        // Long stall in WAIT_NEXT
        rx0 = rxdv_cnt;
        send(8'h81, 1'b0, 8'h18);
        wait_rx(rx0 + 1);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (o_SPI_CS_n !== 1'b0 || o_SPI_Clk !== 1'b0 || o_SPI_MOSI !== 1'b1 || o_TX_Ready !== 1'b1) bad++;
            idle(1);
        end
        check("stall_hold", bad, 0);
        send(8'h00, 1'b1, 8'hF0);
        wait_rx(rx0 + 2);
        wait_idle();

        // Reset after the 7th SCLK edge
        base = sclk_toggles;
        rx0 = rxdv_cnt;
        send(8'h6E, 1'b1, 8'hAB);
        n = 0;
        while (sclk_toggles < base + 7 && n < 500) begin
            @(negedge i_Clk);
            n++;
        end
        check("abort_reached_edge7", sclk_toggles - base, 7);
        i_Rst = 1'b1;
        @(posedge i_Clk);
        #1;
        check("abort_cs_n", int'(o_SPI_CS_n), 1);
        check("abort_sclk", int'(o_SPI_Clk), 0);
        check("abort_ready", int'(o_TX_Ready), 1);
        check("abort_rx_byte", int'(o_RX_Byte), 0);
        i_Rst = 1'b0;
        idle(20);
        check("abort_no_rx_dv", rxdv_cnt, rx0);
        exp_q.delete();
        slv_resp_q.delete();
        send(8'hC3, 1'b1, 8'h69);
        wait_rx(rx0 + 1);
        wait_idle();

        // Random bursts with random inter-byte gaps
        sclk_toggles = 0;
        rx0 = rxdv_cnt;
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom);
            last = (i == 23) || ($urandom_range(0, 2) == 0);
            idle($urandom_range(0, 3));
            send(b, last, 8'($urandom));
            if (last) begin
                wait_rx(rx0 + i + 1);
                wait_idle();
            end
        end
        check("rand_rx_count", rxdv_cnt - rx0, 24);
        check("rand_toggles", sclk_toggles, 24 * 16);
        check("final_exp_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_master.md
# spi_master

SPI mode-0 master for byte-oriented transactions, the controller-side counterpart of the design's `spi_slave`. It runs in the system clock domain and divides that clock down to the SPI clock. It serialises bytes on MOSI MSb-first and deserialises MISO into bytes. Chip select stays asserted across multi-byte bursts until a byte flagged as last has been transferred.

## Interface
- `CLKS_PER_HALF_BIT`, default 4: system clocks per SCLK half-period; must be ≥2.
- `CS_SETUP_CLKS`, default 2: clocks from CS_n falling to the first SCLK half-period; must be ≥1.
- `CS_INACTIVE_CLKS`, default 4: minimum clocks CS_n stays high between transactions; must be ≥1.
- `i_Clk`  in  1  system clock; all logic is on the rising edge.
- `i_Rst`  in  1  reset, synchronous, active-high.
- `i_TX_Byte`  in  8  byte to send; sampled when `i_TX_DV` and `o_TX_Ready` are both high.
- `i_TX_DV`  in  1  byte-valid strobe.
- `i_TX_Last`  in  1  sampled with `i_TX_DV`; 1 means this byte ends the transaction.
- `o_TX_Ready`  out  1  master can accept a byte this cycle.
- `o_RX_DV`  out  1  one-cycle pulse; `o_RX_Byte` is valid.
- `o_RX_Byte`  out  8  byte received on MISO; holds its value until the next pulse.
- `o_SPI_Clk`  out  1  SCLK, idles low (CPOL=0).
- `i_SPI_MISO`  in  1  serial data from the slave.
- `o_SPI_MOSI`  out  1  serial data to the slave.
- `o_SPI_CS_n`  out  1  chip select, active-low.

## Operation
- All outputs are registered except `o_TX_Ready`, which is decoded from the state (high in IDLE and WAIT_NEXT).
- States:
  - IDLE: CS_n=1, SCLK=0, ready=1.
    - Accept → CS_SETUP: load shift-out register, drive MOSI=bit7, CS_n=0, latch last flag.
  - CS_SETUP: count `CS_SETUP_CLKS` cycles → TRANSFER.
  - TRANSFER: half-bit counter 0..`CLKS_PER_HALF_BIT`-1.
    - On wrap, toggle SCLK and increment a 4-bit edge counter.
    - Odd toggles (1st, 3rd, …, 15th) are rising edges.
    - Even toggles (2nd…16th) are falling edges. On each falling edge:
      - Sample `i_SPI_MISO` (its value before that clock edge) into the shift-in register, LSb in, shifting toward MSb.
      - Except after the 16th edge, shift MOSI to the next lower bit.
    - The partner `spi_slave` samples MOSI on the rising edge and launches MISO on the rising edge, so this phasing meets both.
    - On the 16th edge: `o_RX_Byte` is loaded with the completed shift-in value and `o_RX_DV`=1 in the same cycle as SCLK returns low.
    - Then go to CS_HOLD if the last flag is set, else WAIT_NEXT.
  - WAIT_NEXT: CS_n=0, SCLK=0, MOSI holds its last value, ready=1.
    - No timeout.
    - Accept → TRANSFER directly, with MOSI=new bit7 and no CS setup.
  - CS_HOLD: `CLKS_PER_HALF_BIT` cycles with CS_n=0, then CS_n=1 → CS_INACTIVE.
  - CS_INACTIVE: count `CS_INACTIVE_CLKS` cycles with ready=0 → IDLE.
- `i_TX_DV` while ready=0 is ignored; the byte is dropped and no error is flagged.
- Counters are sized with `$clog2` of their parameter. The edge counter is 4 bits and wraps 15→0 only on leaving TRANSFER.

## Timing
- Reset values, one cycle after `i_Rst` is sampled high: state=IDLE, CS_n=1, SCLK=0, MOSI=0, `o_RX_DV`=0, `o_RX_Byte`=0x00, `o_TX_Ready`=1, all counters 0.
- Reset mid-transfer aborts immediately. No `o_RX_DV` is produced and the partial byte is discarded.
- `i_TX_DV` is ignored while `i_Rst` is high.
- Let H=`CLKS_PER_HALF_BIT`, S=`CS_SETUP_CLKS`, and let the accept cycle in IDLE be cycle 0:
  - CS_n falls at cycle 1.
  - First rising SCLK edge at cycle 1+S+H.
  - `o_RX_DV` at cycle 1+S+16H.
  - For a last byte, CS_n rises at 1+S+17H.
  - Ready returns at 1+S+17H+`CS_INACTIVE_CLKS`.
- In WAIT_NEXT, ready is high in the same cycle as `o_RX_DV`. An accept in that cycle t restarts TRANSFER at t+1, giving the minimum inter-byte gap: SCLK low for H+1 cycles.
- The SCLK period is exactly 2H for every bit, with a 50% duty cycle.

## Test plan
All scenarios use H=2, S=2, CS_INACTIVE_CLKS=4.
- Single byte 0xA5 with last=1; slave model returns 0x3C.
  - MOSI at each rising edge reads 1,0,1,0,0,1,0,1.
  - `o_RX_Byte`=0x3C with `o_RX_DV` at cycle 35.
  - CS_n rises at cycle 37; ready rises at cycle 41.
- Burst 0x01 (last=0) then 0x80 (last=1), with the second DV in the `o_RX_DV` cycle.
  - CS_n stays low throughout and there is exactly 32 SCLK toggles.
  - Two `o_RX_DV` pulses, 33 cycles apart.
- Loopback MISO=MOSI with 0x5A → `o_RX_Byte`=0x5A.
- `i_TX_DV` with 0xFF pulsed during TRANSFER and during CS_INACTIVE → ignored; no extra SCLK edges and transmitted data is unchanged.
- Stall in WAIT_NEXT for 100 cycles after byte 0x81 → CS_n=0, SCLK=0 and MOSI=1 held; a following byte 0x00 (last=1) completes normally.
- Assert `i_Rst` after the 7th SCLK edge → next cycle CS_n=1, SCLK=0, ready=1, no `o_RX_DV`; a subsequent 0xC3 transfer then completes correctly.
